load_store_unit: RTL and testbench

//  Sits between the execute/ALU stage and the word-indexed data memory.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_if.sv | 43 ++++
 rtl/load_formatter.sv | 30 +++
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] CAUSE_NONE        = 4'd0;
    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_RESP = 1'b1
    } lsu_state_t;

    // funct3[1:0] encodes access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic r;
        r = 1'b0;
        case (f3[1:0])
            2'b01:   r = (off == 2'd3);
            2'b10:   r = (off != 2'd0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_if
// Description : Execute-side request and data-memory strobe bundle of the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_if #(
    parameter int XLEN = 32
);
    logic            mem_rd_i;
    logic            mem_wr_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] st_data_i;
    logic [XLEN-1:0] dm_addrL_o;
    logic [XLEN-1:0] dm_addrS_o;
    logic [XLEN-1:0] dm_data_wr_o;
    logic            dm_wr_E_o;
    logic            dm_cs_E_o;
    logic [3:0]      dm_mask_o;
    logic [XLEN-1:0] dm_data_rd_i;
    logic [XLEN-1:0] ld_data_o;
    logic            ld_valid_o;
    logic            stall_o;
    logic            exc_o;
    logic [3:0]      exc_cause_o;
    logic [XLEN-1:0] fault_addr_o;

    modport slave (
        input  mem_rd_i, mem_wr_i, funct3_i, addr_i, st_data_i, dm_data_rd_i,
        output dm_addrL_o, dm_addrS_o, dm_data_wr_o, dm_wr_E_o, dm_cs_E_o,
               dm_mask_o, ld_data_o, ld_valid_o, stall_o, exc_o, exc_cause_o,
               fault_addr_o
    );

    modport master (
        output mem_rd_i, mem_wr_i, funct3_i, addr_i, st_data_i, dm_data_rd_i,
        input  dm_addrL_o, dm_addrS_o, dm_data_wr_o, dm_wr_E_o, dm_cs_E_o,
               dm_mask_o, ld_data_o, ld_valid_o, stall_o, exc_o, exc_cause_o,
               fault_addr_o
    );
endinterface : lsu_if
`default_nettype wire

// File: rtl/load_formatter.sv
`default_nettype none
// ============================================================================
// Module      : load_formatter
// Description : Lane-selects and sign/zero-extends a memory word for loads.
// Revision    : 1.0 - initial release
// ============================================================================
module load_formatter
    import lsu_pkg::*;
(
    input  wire logic [2:0]  funct3,
    input  wire logic [1:0]  off,
    input  wire logic [31:0] word,
    output logic      [31:0] data
);
    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = word >> {off, 3'b000};
        data      = '0;
        case (funct3)
            F3_LB:   data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LW:   data = w_shifted;
            F3_LBU:  data = {24'h0, w_shifted[7:0]};
            F3_LHU:  data = {16'h0, w_shifted[15:0]};
            default: data = '0;
        endcase
    end
endmodule : load_formatter
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Byte-addressed load/store front end for word-indexed data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DMEM_WORDS = 256,
    parameter int XLEN       = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    lsu_if.slave      bus
);
    lsu_state_t      r_state;
    lsu_state_t      w_state_next;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [XLEN-1:0] r_fault_addr;

    logic [1:0]      w_off;
    logic [XLEN-1:0] w_word_idx;
    logic            w_st_legal;
    logic            w_ld_legal;
    logic            w_misalign;
    logic            w_fault;
    logic            w_st_req;
    logic            w_ld_req;
    logic            w_st_go;
    logic            w_ld_go;
    logic            w_exc;
    logic [3:0]      w_cause;
    logic            w_cs_n;
    logic            w_wr;
    logic            w_stall;
    logic            w_ld_valid;
    logic [3:0]      w_mask;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_fmt;

    assign w_off      = bus.addr_i[1:0];
    assign w_word_idx = {2'b00, bus.addr_i[XLEN-1:2]};
    assign w_st_legal = (bus.funct3_i == F3_SB) || (bus.funct3_i == F3_SH) ||
                        (bus.funct3_i == F3_SW);
    assign w_ld_legal = w_st_legal || (bus.funct3_i == F3_LBU) ||
                        (bus.funct3_i == F3_LHU);
    assign w_misalign = is_misaligned(bus.funct3_i, w_off);
    assign w_fault    = (w_word_idx >= XLEN'(DMEM_WORDS));

    // A store outranks a load; a load is only accepted from IDLE since the
    // held instruction stays on the inputs during the response cycle.
    assign w_st_req = bus.mem_wr_i && w_st_legal;
    assign w_ld_req = bus.mem_rd_i && !bus.mem_wr_i && w_ld_legal && (r_state == IDLE);
    assign w_st_go  = w_st_req && !w_misalign && !w_fault;
    assign w_ld_go  = w_ld_req && !w_misalign && !w_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cs_n       = 1'b1;
        w_wr         = 1'b0;
        w_stall      = 1'b0;
        w_exc        = 1'b0;
        w_cause      = CAUSE_NONE;
        w_ld_valid   = 1'b0;
        case (r_state)
            IDLE:      w_state_next = w_ld_go ? LOAD_RESP : IDLE;
            LOAD_RESP: begin
                w_state_next = IDLE;
                w_ld_valid   = 1'b1;
            end
            default:   w_state_next = IDLE;
        endcase
        // Strobes are held inactive for as long as reset is asserted.
        if (!rst) begin
            if (w_st_go) begin
                w_cs_n = 1'b0;
                w_wr   = 1'b1;
            end else if (w_ld_go) begin
                w_cs_n  = 1'b0;
                w_stall = 1'b1;
            end
            if (w_st_req && (w_misalign || w_fault)) begin
                w_exc   = 1'b1;
                w_cause = w_misalign ? CAUSE_ST_MISALIGN : CAUSE_ST_FAULT;
            end else if (w_ld_req && (w_misalign || w_fault)) begin
                w_exc   = 1'b1;
                w_cause = w_misalign ? CAUSE_LD_MISALIGN : CAUSE_LD_FAULT;
            end
        end
    end

    always_comb begin
        w_mask  = 4'b0000;
        w_wdata = bus.st_data_i;
        case (bus.funct3_i)
            F3_SB: begin
                w_mask  = 4'b0001 << w_off;
                w_wdata = {4{bus.st_data_i[7:0]}};
            end
            F3_SH: begin
                w_mask  = 4'b0011 << w_off;
                w_wdata = {2{bus.st_data_i[15:0]}};
            end
            F3_SW:   w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
        if (!w_wr) begin
            w_mask = 4'b0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_funct3 <= 3'b000;
            r_off    <= 2'b00;
        end else if (w_ld_go) begin
            r_funct3 <= bus.funct3_i;
            r_off    <= w_off;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault_addr <= '0;
        end else if (w_exc) begin
            r_fault_addr <= bus.addr_i;
        end
    end

    load_formatter u_load_formatter (
        .funct3 (r_funct3),
        .off    (r_off),
        .word   (bus.dm_data_rd_i),
        .data   (w_fmt)
    );

    assign bus.dm_addrL_o   = w_word_idx;
    assign bus.dm_addrS_o   = w_word_idx;
    assign bus.dm_data_wr_o = w_wdata;
    assign bus.dm_wr_E_o    = w_wr;
    assign bus.dm_cs_E_o    = w_cs_n;
    assign bus.dm_mask_o    = w_mask;
    assign bus.ld_valid_o   = w_ld_valid;
    assign bus.ld_data_o    = w_ld_valid ? w_fmt : '0;
    assign bus.stall_o      = w_stall;
    assign bus.exc_o        = w_exc;
    assign bus.exc_cause_o  = w_cause;
    assign bus.fault_addr_o = r_fault_addr;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit with a registered-read memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] mem [0:255];
    logic [31:0] ld_q [$];
    logic [3:0]  exc_q [$];
    logic [67:0] st_q [$];

    lsu_if #(.XLEN(32)) bus ();

    load_store_unit #(.DMEM_WORDS(256), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered read on posedge, masked byte writes on negedge.
    always @(posedge clk) begin
        if (!bus.dm_cs_E_o && !bus.dm_wr_E_o) begin
            bus.dm_data_rd_i <= mem[bus.dm_addrL_o[7:0]];
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4] <= 32'hDEADBEEF;
            mem[8] <= 32'h11112222;
        end else if (!bus.dm_cs_E_o && bus.dm_wr_E_o) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.dm_mask_o[b]) mem[bus.dm_addrS_o[7:0]][8*b +: 8] <= bus.dm_data_wr_o[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected responses whenever the DUT presents one.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ld_valid_o) begin
                if (ld_q.size() == 0) chk("unexpected_ld_valid", 68'd1, 68'd0);
                else chk("ld_data", 68'(bus.ld_data_o), 68'(ld_q.pop_front()));
            end
            if (bus.exc_o) begin
                if (exc_q.size() == 0) chk("unexpected_exc", 68'd1, 68'd0);
                else chk("exc_cause", 68'(bus.exc_cause_o), 68'(exc_q.pop_front()));
            end
            if (bus.dm_wr_E_o) begin
                if (st_q.size() == 0) chk("unexpected_store", 68'd1, 68'd0);
                else chk("store_addr_mask_data",
                         {bus.dm_addrS_o, bus.dm_mask_o, bus.dm_data_wr_o}, st_q.pop_front());
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        bus.mem_rd_i  = rd;
        bus.mem_wr_i  = wr;
        bus.funct3_i  = f3;
        bus.addr_i    = addr;
        bus.st_data_i = data;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, addr, 32'h0);
        ld_q.push_back(exp);
        @(negedge clk);
        chk("load_issue_stall", 68'(bus.stall_o), 68'd1);
        chk("load_issue_addrL", 68'(bus.dm_addrL_o), 68'(addr >> 2));
        idle();
        @(negedge clk);
        chk("load_resp_stall", 68'(bus.stall_o), 68'd0);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] mask, input logic [31:0] wdata, input logic rd);
        drive(rd, 1'b1, f3, addr, data);
        st_q.push_back({addr >> 2, mask, wdata});
        @(negedge clk);
        chk("store_stall", 68'(bus.stall_o), 68'd0);
        chk("store_cs", 68'(bus.dm_cs_E_o), 68'd0);
    endtask

    task automatic do_exc(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [3:0] cause);
        drive(rd, wr, f3, addr, 32'h0);
        exc_q.push_back(cause);
        @(negedge clk);
        chk("exc_cs_inactive", 68'(bus.dm_cs_E_o), 68'd1);
        idle();
        @(negedge clk);
        chk("fault_addr", 68'(bus.fault_addr_o), 68'(addr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.mem_rd_i  = 1'b1;
        bus.mem_wr_i  = 1'b1;
        bus.funct3_i  = F3_SW;
        bus.addr_i    = 32'h10;
        bus.st_data_i = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_cs", 68'(bus.dm_cs_E_o), 68'd1);
        chk("rst_wr", 68'(bus.dm_wr_E_o), 68'd0);
        chk("rst_mask", 68'(bus.dm_mask_o), 68'd0);
        chk("rst_stall", 68'(bus.stall_o), 68'd0);
        chk("rst_exc", 68'(bus.exc_o), 68'd0);
        chk("rst_ld_valid", 68'(bus.ld_valid_o), 68'd0);
        chk("rst_ld_data", 68'(bus.ld_data_o), 68'd0);
        chk("rst_fault_addr", 68'(bus.fault_addr_o), 68'd0);
        @(posedge clk);
        #1;
        bus.mem_rd_i = 1'b0;
        bus.mem_wr_i = 1'b0;
        rst = 1'b0;

        do_load(F3_LW, 32'h10, 32'hDEADBEEF);
        do_store(F3_SW, 32'h10, 32'h80FF0000, 4'hF, 32'h80FF0000, 1'b0);

        // Held LB during the response must not reissue; LBU follows back-to-back.
        drive(1'b1, 1'b0, F3_LB, 32'h13, 32'h0);
        ld_q.push_back(32'hFFFFFF80);
        @(negedge clk);
        chk("b2b_issue_stall", 68'(bus.stall_o), 68'd1);
        @(negedge clk);
        chk("b2b_held_no_reissue_cs", 68'(bus.dm_cs_E_o), 68'd1);
        chk("b2b_held_stall", 68'(bus.stall_o), 68'd0);
        do_load(F3_LBU, 32'h13, 32'h00000080);
        do_load(F3_LH,  32'h12, 32'hFFFF80FF);
        do_load(F3_LHU, 32'h12, 32'h000080FF);
        do_load(F3_LH,  32'h11, 32'hFFFFFF00);

        do_store(F3_SH, 32'h22, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 1'b0);
        do_load(F3_LW, 32'h20, 32'hABCD2222);
        do_store(F3_SB, 32'h25, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, 1'b0);
        do_store(F3_SB, 32'h27, 32'h0000003C, 4'b1000, 32'h3C3C3C3C, 1'b0);
        do_load(F3_LW, 32'h24, 32'h3C00A500);
        do_store(F3_SW, 32'h14, 32'h00000055, 4'hF, 32'h00000055, 1'b1);
        do_load(F3_LBU, 32'h14, 32'h00000055);

        do_exc(1'b1, 1'b0, F3_LW, 32'h11,  CAUSE_LD_MISALIGN);
        do_exc(1'b0, 1'b1, F3_SW, 32'h400, CAUSE_ST_FAULT);
        do_exc(1'b1, 1'b0, F3_LH, 32'h13,  CAUSE_LD_MISALIGN);
        do_exc(1'b0, 1'b1, F3_SH, 32'h03,  CAUSE_ST_MISALIGN);
        do_exc(1'b1, 1'b0, F3_LW, 32'h400, CAUSE_LD_FAULT);

        drive(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
        @(negedge clk);
        chk("illegal_f3_cs", 68'(bus.dm_cs_E_o), 68'd1);
        chk("illegal_f3_exc", 68'(bus.exc_o), 68'd0);
        idle();
        @(negedge clk);
        chk("illegal_f3_no_valid", 68'(bus.ld_valid_o), 68'd0);

        // Store arriving during the load response cycle.
        drive(1'b1, 1'b0, F3_LW, 32'h10, 32'h0);
        ld_q.push_back(32'h80FF0000);
        drive(1'b0, 1'b1, F3_SW, 32'h30, 32'hCAFEF00D);
        st_q.push_back({32'd12, 4'hF, 32'hCAFEF00D});
        @(negedge clk);
        chk("resp_store_valid", 68'(bus.ld_valid_o), 68'd1);
        do_load(F3_LW, 32'h30, 32'hCAFEF00D);

        // Reset while in LOAD_RESP drops the pending response.
        drive(1'b1, 1'b0, F3_LW, 32'h10, 32'h0);
        @(posedge clk);
        #1;
        bus.mem_rd_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_in_resp_valid", 68'(bus.ld_valid_o), 68'd0);
        chk("rst_in_resp_data", 68'(bus.ld_data_o), 68'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 68'(bus.ld_valid_o), 68'd0);
        chk("post_rst_cs", 68'(bus.dm_cs_E_o), 68'd1);
        chk("post_rst_stall", 68'(bus.stall_o), 68'd0);
        chk("post_rst_fault_addr", 68'(bus.fault_addr_o), 68'd0);
        do_load(F3_LW, 32'h10, 32'hDEADBEEF);

        repeat (2) @(negedge clk);
        chk("ld_q_drained", 68'(ld_q.size()), 68'd0);
        chk("exc_q_drained", 68'(exc_q.size()), 68'd0);
        chk("st_q_drained", 68'(st_q.size()), 68'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule : tb_load_store_unit
`default_nettype wire
